// File: rtl/line_rasterizer.sv
// Bresenham line rasteriser: takes one centre-origin endpoint pair per handshake and
// emits one candidate pixel per cycle as framebuffer writes, stalling on iPixBusy.
module line_rasterizer #(
    parameter int          H_RES      = 640,
    parameter int          V_RES      = 480,
    parameter logic [11:0] RED_COLOR  = 12'hF00,
    parameter logic [11:0] BLUE_COLOR = 12'h00F,
    parameter logic [11:0] MONO_COLOR = 12'hFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               iPointValid,
    input  logic signed [15:0] iU1,
    input  logic signed [15:0] iV1,
    input  logic signed [15:0] iU2,
    input  logic signed [15:0] iV2,
    input  logic               iIsRed,
    input  logic               iMono,
    output logic               oLineDrawRead,
    output logic               oPixWe,
    output logic [9:0]         oPixX,
    output logic [8:0]         oPixY,
    output logic [11:0]        oPixColor,
    input  logic               iPixBusy,
    input  logic               iClear,
    output logic [15:0]        oLineCount,
    output logic               oIdle
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW} state_t;
    // Colour is kept as an index so its all-zero reset value means blue.
    typedef enum logic [1:0] {C_BLUE, C_RED, C_MONO} color_t;

    state_t             state;
    color_t             color_sel;
    logic signed [17:0] x1, y1, x2, y2, cx, cy;
    logic signed [18:0] dx, dy;
    logic signed [19:0] err;
    logic               sx_neg, sy_neg;
    logic [9:0]         last_x;
    logic [8:0]         last_y;

    logic signed [17:0] map_x1, map_y1, map_x2, map_y2;
    logic signed [18:0] diff_x, diff_y, abs_x, abs_y;
    logic signed [20:0] e2;
    logic signed [19:0] err_next;
    logic               inb, step_x, step_y, advance, at_end, done;

    assign map_x1 = 18'(iU1) + 18'(H_RES / 2);
    assign map_x2 = 18'(iU2) + 18'(H_RES / 2);
    assign map_y1 = 18'(V_RES / 2) - 18'(iV1);
    assign map_y2 = 18'(V_RES / 2) - 18'(iV2);

    assign diff_x = 19'(x2) - 19'(x1);
    assign diff_y = 19'(y2) - 19'(y1);
    assign abs_x  = (diff_x < 0) ? -diff_x : diff_x;
    assign abs_y  = (diff_y < 0) ? -diff_y : diff_y;

    assign inb      = (cx >= 0) && (cx < 18'(H_RES)) && (cy >= 0) && (cy < 18'(V_RES));
    assign e2       = $signed({err, 1'b0});
    assign step_x   = e2 >= 21'(dy);
    assign step_y   = e2 <= 21'(dx);
    // Both axis steps may fire together; err takes the sum of both deltas.
    assign err_next = err + (step_x ? 20'(dy) : 20'sd0) + (step_y ? 20'(dx) : 20'sd0);
    assign at_end   = (cx == x2) && (cy == y2);
    assign advance  = (state == S_DRAW) && (!iPixBusy || !inb);
    assign done     = advance && at_end;

    assign oLineDrawRead = (state == S_IDLE) && iPointValid;
    assign oIdle         = (state == S_IDLE);
    assign oPixWe        = (state == S_DRAW) && inb && !iPixBusy;
    assign oPixX         = (state == S_DRAW) ? cx[9:0] : last_x;
    assign oPixY         = (state == S_DRAW) ? cy[8:0] : last_y;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        oPixColor = BLUE_COLOR;
        case (color_sel)
            C_RED:   oPixColor = RED_COLOR;
            C_MONO:  oPixColor = MONO_COLOR;
            default: oPixColor = BLUE_COLOR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            color_sel  <= C_BLUE;
            x1         <= '0;
            y1         <= '0;
            x2         <= '0;
            y2         <= '0;
            cx         <= '0;
            cy         <= '0;
            dx         <= '0;
            dy         <= '0;
            err        <= '0;
            sx_neg     <= 1'b0;
            sy_neg     <= 1'b0;
            last_x     <= '0;
            last_y     <= '0;
            oLineCount <= '0;
        end else begin
            if (iClear)    oLineCount <= done ? 16'd1 : 16'd0;
            else if (done) oLineCount <= oLineCount + 16'd1;

            case (state)
                S_IDLE: begin
                    if (iPointValid) begin
                        x1        <= map_x1;
                        y1        <= map_y1;
                        x2        <= map_x2;
                        y2        <= map_y2;
                        color_sel <= iMono ? C_MONO : (iIsRed ? C_RED : C_BLUE);
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    dx     <= abs_x;
                    dy     <= -abs_y;
                    err    <= 20'(abs_x) - 20'(abs_y);
                    sx_neg <= !(x1 < x2);
                    sy_neg <= !(y1 < y2);
                    cx     <= x1;
                    cy     <= y1;
                    state  <= S_DRAW;
                end
                S_DRAW: begin
                    last_x <= cx[9:0];
                    last_y <= cy[8:0];
                    if (advance) begin
                        if (at_end) begin
                            state <= S_IDLE;
                        end else begin
                            err <= err_next;
                            if (step_x) cx <= sx_neg ? cx - 18'sd1 : cx + 18'sd1;
                            if (step_y) cy <= sy_neg ? cy - 18'sd1 : cy + 18'sd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_rasterizer.sv
// Self-checking bench for line_rasterizer: table-driven spec vectors, hand-written
// corner sequences and random lines against a plain-integer Bresenham model.
module tb_line_rasterizer;
    localparam int H_RES = 640;
    localparam int V_RES = 480;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               iPointValid = 1'b0;
    logic signed [15:0] iU1 = '0, iV1 = '0, iU2 = '0, iV2 = '0;
    logic               iIsRed = 1'b0, iMono = 1'b0;
    logic               iPixBusy = 1'b0, iClear = 1'b0;
    logic               oLineDrawRead, oPixWe, oIdle;
    logic [9:0]         oPixX;
    logic [8:0]         oPixY;
    logic [11:0]        oPixColor;
    logic [15:0]        oLineCount;

    line_rasterizer dut (
        .clk(clk), .rst_n(rst_n), .iPointValid(iPointValid),
        .iU1(iU1), .iV1(iV1), .iU2(iU2), .iV2(iV2),
        .iIsRed(iIsRed), .iMono(iMono), .oLineDrawRead(oLineDrawRead),
        .oPixWe(oPixWe), .oPixX(oPixX), .oPixY(oPixY), .oPixColor(oPixColor),
        .iPixBusy(iPixBusy), .iClear(iClear), .oLineCount(oLineCount), .oIdle(oIdle)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor samples on the falling edge, away from the active edge.
    int wr_x[$], wr_y[$], wr_c[$];
    int accepts = 0, active_cycles = 0;
    always @(negedge clk) begin
        if (oPixWe === 1'b1) begin
            wr_x.push_back(int'(oPixX));
            wr_y.push_back(int'(oPixY));
            wr_c.push_back(int'(oPixColor));
        end
        if (oLineDrawRead === 1'b1) accepts++;
        if (oIdle === 1'b0) active_cycles++;
    end

    bit rand_busy = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rand_busy) iPixBusy = ($urandom_range(3) == 0);
    end

    // Reference model: walk the segment with integer Bresenham, keep on-screen points.
    int exp_x[$], exp_y[$], exp_c[$];

    function automatic int color_of(input bit red, input bit mono);
        return mono ? 32'hFFF : (red ? 32'hF00 : 32'h00F);
    endfunction

    task automatic model_line(input int u1, input int v1, input int u2, input int v2,
                              input bit red, input bit mono, output int npts);
        int x, y, xe, ye, dx, dy, sx, sy, err, e2;
        x  = u1 + H_RES / 2;  y  = V_RES / 2 - v1;
        xe = u2 + H_RES / 2;  ye = V_RES / 2 - v2;
        dx = (xe > x) ? xe - x : x - xe;
        dy = -((ye > y) ? ye - y : y - ye);
        sx = (x < xe) ? 1 : -1;
        sy = (y < ye) ? 1 : -1;
        err = dx + dy;
        npts = 0;
        forever begin
            npts++;
            if (x >= 0 && x < H_RES && y >= 0 && y < V_RES) begin
                exp_x.push_back(x); exp_y.push_back(y); exp_c.push_back(color_of(red, mono));
            end
            if (x == xe && y == ye) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    task automatic clear_queues();
        wr_x.delete(); wr_y.delete(); wr_c.delete();
        exp_x.delete(); exp_y.delete(); exp_c.delete();
        accepts = 0; active_cycles = 0;
    endtask

    task automatic compare_pixels(input string tag);
        int nbad = 0;
        check({tag, " nwrites"}, wr_x.size(), exp_x.size());
        for (int i = 0; i < wr_x.size() && i < exp_x.size(); i++)
            if (wr_x[i] != exp_x[i] || wr_y[i] != exp_y[i] || wr_c[i] != exp_c[i]) nbad++;
        check({tag, " pixel_mismatches"}, nbad, 0);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int t = 0;
        while (oIdle !== 1'b1 && t < limit) begin
            @(posedge clk); #1;
            t++;
        end
        check({tag, " finished_in_time"}, t < limit, 1);
    endtask

    task automatic run_line(input int u1, input int v1, input int u2, input int v2,
                            input bit red, input bit mono, input string tag,
                            input bit check_timing, output int npts);
        logic [15:0] lc0;
        @(posedge clk); #1;
        clear_queues();
        model_line(u1, v1, u2, v2, red, mono, npts);
        lc0 = oLineCount;
        iU1 = 16'(u1); iV1 = 16'(v1); iU2 = 16'(u2); iV2 = 16'(v2);
        iIsRed = red; iMono = mono; iPointValid = 1'b1;
        @(posedge clk); #1;
        iPointValid = 1'b0;
        wait_idle(tag, 4 * npts + 50);
        check({tag, " accepts"}, accepts, 1);
        check({tag, " line_count"}, oLineCount, lc0 + 16'd1);
        compare_pixels(tag);
        if (check_timing) check({tag, " active_cycles"}, active_cycles, npts + 1);
    endtask

    typedef struct {
        int u1, v1, u2, v2;
        bit red, mono;
        int n_wr, fx, fy, n_draw;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int npts, t, pts_a;
        logic [15:0] lc0;

        vecs[0] = '{0, 0, 3, 0, 1'b1, 1'b0, 4, 320, 240, 4};
        vecs[1] = '{0, 0, 0, -2, 1'b0, 1'b0, 3, 320, 240, 3};
        vecs[2] = '{-2, 2, 2, -2, 1'b0, 1'b1, 5, 318, 238, 5};
        vecs[3] = '{0, 0, 4, 1, 1'b0, 1'b0, 5, 320, 240, 5};
        vecs[4] = '{5, 5, 5, 5, 1'b1, 1'b0, 1, 325, 235, 1};
        vecs[5] = '{-400, 0, -330, 0, 1'b1, 1'b0, 0, 0, 0, 71};
        vecs[6] = '{-325, 0, -318, 0, 1'b0, 1'b0, 3, 0, 240, 8};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst oPixWe", oPixWe, 0);
        check("rst oLineDrawRead", oLineDrawRead, 0);
        check("rst oPixX", oPixX, 0);
        check("rst oPixY", oPixY, 0);
        check("rst oPixColor", oPixColor, 12'h00F);
        check("rst oLineCount", oLineCount, 0);
        check("rst oIdle", oIdle, 1);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_line(vecs[i].u1, vecs[i].v1, vecs[i].u2, vecs[i].v2,
                     vecs[i].red, vecs[i].mono, tag, 1'b1, npts);
            check({tag, " table_nwrites"}, wr_x.size(), vecs[i].n_wr);
            check({tag, " table_draw_cycles"}, active_cycles - 1, vecs[i].n_draw);
            if (vecs[i].n_wr > 0 && wr_x.size() > 0) begin
                check({tag, " first_x"}, wr_x[0], vecs[i].fx);
                check({tag, " first_y"}, wr_y[0], vecs[i].fy);
                check({tag, " color"}, wr_c[0], color_of(vecs[i].red, vecs[i].mono));
            end
        end

        // Backpressure on the 2nd pixel of (0,0)-(3,0)
        @(posedge clk); #1;
        clear_queues();
        model_line(0, 0, 3, 0, 1'b1, 1'b0, npts);
        iU1 = 0; iV1 = 0; iU2 = 3; iV2 = 0; iIsRed = 1'b1; iMono = 1'b0; iPointValid = 1'b1;
        @(posedge clk); #1 iPointValid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 iPixBusy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("busy oPixWe", oPixWe, 0);
            check("busy oPixX_held", oPixX, 321);
            @(posedge clk); #1;
        end
        iPixBusy = 1'b0;
        wait_idle("busy", 100);
        compare_pixels("busy");
        check("busy active_cycles", active_cycles, 8);

        // Back-to-back with iPointValid held high
        @(posedge clk); #1;
        clear_queues();
        model_line(5, 5, 5, 5, 1'b1, 1'b0, pts_a);
        model_line(1, -1, 2, -2, 1'b0, 1'b0, npts);
        iU1 = 5; iV1 = 5; iU2 = 5; iV2 = 5; iIsRed = 1'b1; iMono = 1'b0; iPointValid = 1'b1;
        @(negedge clk);
        check("b2b first_accept", oLineDrawRead, 1);
        @(posedge clk); #1;
        iU1 = 1; iV1 = -1; iU2 = 2; iV2 = -2; iIsRed = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (oLineDrawRead !== 1'b1 && t < 20);
        check("b2b accept_gap", t, 3);
        @(posedge clk); #1 iPointValid = 1'b0;
        wait_idle("b2b", 100);
        check("b2b accepts", accepts, 2);
        compare_pixels("b2b");

        // Random lines, half of them with random backpressure
        for (int i = 0; i < 24; i++) begin
            int ru1, rv1, ru2, rv2;
            ru1 = int'($urandom_range(720)) - 360;
            rv1 = int'($urandom_range(720)) - 360;
            ru2 = int'($urandom_range(720)) - 360;
            rv2 = int'($urandom_range(720)) - 360;
            rand_busy = i[0];
            run_line(ru1, rv1, ru2, rv2, 1'($urandom_range(1)), 1'($urandom_range(1)),
                     $sformatf("rnd%0d", i), !i[0], npts);
            rand_busy = 1'b0;
            iPixBusy = 1'b0;
        end

        // Clear coincident with completion gives 1; a lone clear gives 0
        @(posedge clk); #1;
        lc0 = oLineCount;
        check("clear precondition_nonzero", lc0 != 16'd0, 1);
        iU1 = 5; iV1 = 5; iU2 = 5; iV2 = 5; iPointValid = 1'b1;
        @(posedge clk); #1 iPointValid = 1'b0;
        @(posedge clk); #1 iClear = 1'b1;
        @(posedge clk); #1 iClear = 1'b0;
        check("clear_coincident idle", oIdle, 1);
        check("clear_coincident count", oLineCount, 1);
        iClear = 1'b1;
        @(posedge clk); #1 iClear = 1'b0;
        check("clear_alone count", oLineCount, 0);

        // Asynchronous reset mid-line
        iU1 = -300; iV1 = 0; iU2 = 300; iV2 = 0; iIsRed = 1'b1; iPointValid = 1'b1;
        @(posedge clk); #1 iPointValid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("midline busy_before_reset", oIdle, 0);
        rst_n = 1'b0;
        #1;
        check("midrst oPixWe", oPixWe, 0);
        check("midrst oIdle", oIdle, 1);
        check("midrst oLineCount", oLineCount, 0);
        check("midrst oPixX", oPixX, 0);
        check("midrst oPixColor", oPixColor, 12'h00F);
        @(posedge clk); #1 rst_n = 1'b1;
        run_line(1, 1, 3, 2, 1'b0, 1'b1, "post_reset", 1'b1, npts);
        check("post_reset count", oLineCount, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
